// File: rtl/scan_pkg.sv
// Shared sizes and state type for the row scan controller.
package scan_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/row_scan_ctrl_if.sv
// Row buffer write port and row/column drive signals of the row scan controller.
interface row_scan_ctrl_if;
  import scan_pkg::*;

  logic             en;
  logic             wr_en;
  logic [ROW_W-1:0] wr_addr;
  logic [COLS-1:0]  wr_data;
  logic [ROW_W-1:0] row_sel;
  logic [COLS-1:0]  col_out;
  logic             blank;
  logic             frame_done;

  modport master (
    output en, wr_en, wr_addr, wr_data,
    input  row_sel, col_out, blank, frame_done
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data,
    output row_sel, col_out, blank, frame_done
  );

endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter; o_tc_c is high while the count sits at zero.
module scan_timer
  import scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc_c = (r_count == '0);

endmodule

// File: rtl/row_scan_ctrl.sv
// Row scan controller: walks an 8x8 row buffer onto a row decoder with dwell/blank timing.
// Define SCAN_DOUBLE_BUFFER_EN for a back buffer that is copied to the display buffer per frame.
module row_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input logic            clk,
  input logic            rst_n,
  row_scan_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

  scan_state_e      r_state;
  logic [ROW_W-1:0] r_row_sel;
  logic [COLS-1:0]  r_col_out;
  logic             r_blank;
  logic             r_frame_done;
  logic [COLS-1:0]  r_buf [ROWS];

  logic             w_tc_c;
  logic             w_clear_c;
  logic             w_load_c;
  logic [CNT_W-1:0] w_load_val_c;
  logic [ROW_W-1:0] w_next_row_c;
  logic [ROW_W-1:0] w_tgt_row_c;
  logic             w_wrap_c;
  logic [COLS-1:0]  w_col_c;

  scan_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear_c),
    .i_load     (w_load_c),
    .i_load_val (w_load_val_c),
    .o_tc_c     (w_tc_c)
  );

  // Timer control and the row whose pattern is registered onto col_out at this edge.
  always_comb begin
    w_clear_c    = 1'b0;
    w_load_c     = 1'b0;
    w_load_val_c = DWELL_LOAD;
    w_next_row_c = r_row_sel + ROW_W'(1);
    w_tgt_row_c  = r_row_sel;
    w_wrap_c     = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear_c   = !bus.en;
        w_load_c    = bus.en;
        w_tgt_row_c = '0;
      end
      DWELL: begin
        w_clear_c    = !bus.en;
        w_load_c     = bus.en && w_tc_c;
        w_load_val_c = BLANK_LOAD;
      end
      BLANK: begin
        w_clear_c   = !bus.en;
        w_load_c    = bus.en && w_tc_c;
        w_tgt_row_c = w_next_row_c;
        w_wrap_c    = bus.en && w_tc_c && (r_row_sel == LAST_ROW);
      end
      default: begin
        w_clear_c = 1'b1;
      end
    endcase
  end

`ifdef SCAN_DOUBLE_BUFFER_EN
  logic [COLS-1:0] r_back [ROWS];
  logic            w_swap_c;

  assign w_swap_c = ((r_state == IDLE) && bus.en) || w_wrap_c;

  // On a swap edge the display buffer is being reloaded, so read through from the back buffer.
  always_comb begin
    w_col_c = r_buf[w_tgt_row_c];
    if (w_swap_c) begin
      w_col_c = (bus.wr_en && (bus.wr_addr == w_tgt_row_c)) ? bus.wr_data : r_back[w_tgt_row_c];
    end
  end

  // Writes land in the back buffer; the display buffer takes a full snapshot on a swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        r_back[i] <= '0;
        r_buf[i]  <= '0;
      end
    end else begin
      if (bus.wr_en) begin
        r_back[bus.wr_addr] <= bus.wr_data;
      end
      if (w_swap_c) begin
        for (int unsigned i = 0; i < ROWS; i++) begin
          r_buf[i] <= (bus.wr_en && (bus.wr_addr == ROW_W'(i))) ? bus.wr_data : r_back[i];
        end
      end
    end
  end
`else
  // Same-edge write to the displayed row bypasses the buffer so it shows one cycle later.
  always_comb begin
    w_col_c = r_buf[w_tgt_row_c];
    if (bus.wr_en && (bus.wr_addr == w_tgt_row_c)) begin
      w_col_c = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        r_buf[i] <= '0;
      end
    end else if (bus.wr_en) begin
      r_buf[bus.wr_addr] <= bus.wr_data;
    end
  end
`endif

  // Scan FSM with registered row, column and blanking outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row_sel    <= '0;
      r_col_out    <= '0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state   <= DWELL;
            r_row_sel <= '0;
            r_col_out <= w_col_c;
            r_blank   <= 1'b0;
          end
        end
        DWELL: begin
          if (!bus.en) begin
            r_state   <= IDLE;
            r_row_sel <= '0;
            r_col_out <= '0;
            r_blank   <= 1'b1;
          end else if (w_tc_c) begin
            r_state   <= BLANK;
            r_col_out <= '0;
            r_blank   <= 1'b1;
          end else begin
            r_col_out <= w_col_c;
          end
        end
        BLANK: begin
          if (!bus.en) begin
            r_state   <= IDLE;
            r_row_sel <= '0;
            r_col_out <= '0;
            r_blank   <= 1'b1;
          end else if (w_tc_c) begin
            r_state      <= DWELL;
            r_row_sel    <= w_next_row_c;
            r_col_out    <= w_col_c;
            r_blank      <= 1'b0;
            r_frame_done <= w_wrap_c;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_row_sel <= '0;
          r_col_out <= '0;
          r_blank   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.row_sel    = r_row_sel;
  assign bus.col_out    = r_col_out;
  assign bus.blank      = r_blank;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Scoreboard bench for row_scan_ctrl: default timing and 1/1 timing instances share one stimulus stream.
module tb_row_scan_ctrl;
  import scan_pkg::*;

  typedef struct packed {
    logic [2:0] row;
    logic [7:0] col;
    logic       blank;
    logic       fd;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       drv_en;
  logic       drv_wr_en;
  logic [2:0] drv_wr_addr;
  logic [7:0] drv_wr_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : gen_u
    localparam int unsigned D    = (g == 0) ? 4 : 1;
    localparam int unsigned B    = 1;
    localparam int unsigned SLOT = D + B;
    localparam int unsigned PER  = ROWS * SLOT;

    row_scan_ctrl_if u_if ();

    assign u_if.en      = drv_en;
    assign u_if.wr_en   = drv_wr_en;
    assign u_if.wr_addr = drv_wr_addr;
    assign u_if.wr_data = drv_wr_data;

    row_scan_ctrl #(
      .DWELL_CYCLES (D),
      .BLANK_CYCLES (B)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );

    exp_t        q[$];
    bit          m_run;
    int unsigned m_p;
    logic [7:0]  m_back  [8];
    logic [7:0]  m_front [8];

    // Reference: position within the scan since start decides row, phase and frame boundary.
    always @(posedge clk) begin : model
      exp_t        e;
      int unsigned r;
      bit          swap;
      swap = 1'b0;
      if (!rst_n) begin
        m_run = 1'b0;
        m_p   = 0;
        for (int i = 0; i < 8; i++) begin
          m_back[i]  = 8'h00;
          m_front[i] = 8'h00;
        end
      end else begin
        if (drv_wr_en) m_back[drv_wr_addr] = drv_wr_data;
        if (!m_run) begin
          if (drv_en) begin
            m_run = 1'b1;
            m_p   = 0;
            swap  = 1'b1;
          end
        end else if (!drv_en) begin
          m_run = 1'b0;
        end else begin
          m_p++;
          swap = ((m_p % PER) == 0);
        end
        if (swap) begin
          for (int i = 0; i < 8; i++) m_front[i] = m_back[i];
        end
      end
      if (m_run) begin
        r       = (m_p / SLOT) % ROWS;
        e.row   = r[2:0];
        e.blank = ((m_p % SLOT) >= D);
`ifdef SCAN_DOUBLE_BUFFER_EN
        e.col   = e.blank ? 8'h00 : m_front[r[2:0]];
`else
        e.col   = e.blank ? 8'h00 : m_back[r[2:0]];
`endif
        e.fd    = (m_p != 0) && ((m_p % PER) == 0);
      end else begin
        e.row   = 3'd0;
        e.col   = 8'h00;
        e.blank = 1'b1;
        e.fd    = 1'b0;
      end
      q.push_back(e);
    end

    always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk($sformatf("u%0d row_sel", g), 32'(u_if.row_sel), 32'(e.row));
        chk($sformatf("u%0d col_out", g), 32'(u_if.col_out), 32'(e.col));
        chk($sformatf("u%0d blank", g), 32'(u_if.blank), 32'(e.blank));
        chk($sformatf("u%0d frame_done", g), 32'(u_if.frame_done), 32'(e.fd));
      end
    end

    // Asynchronous reset: drop pending expectations and check outputs before any clock edge.
    always @(negedge rst_n) begin : async_rst
      q.delete();
      #1;
      chk($sformatf("u%0d async row_sel", g), 32'(u_if.row_sel), 32'd0);
      chk($sformatf("u%0d async col_out", g), 32'(u_if.col_out), 32'd0);
      chk($sformatf("u%0d async blank", g), 32'(u_if.blank), 32'd1);
      chk($sformatf("u%0d async frame_done", g), 32'(u_if.frame_done), 32'd0);
    end
  end

  initial begin
    rst_n       = 1'b0;
    drv_en      = 1'b0;
    drv_wr_en   = 1'b0;
    drv_wr_addr = 3'd0;
    drv_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Walking-one pattern loaded while idle.
    for (int r = 0; r < 8; r++) begin
      drv_wr_en   = 1'b1;
      drv_wr_addr = 3'(r);
      drv_wr_data = 8'(8'h01 << r);
      @(negedge clk);
    end
    drv_wr_en = 1'b0;
    drv_en    = 1'b1;
    repeat (100) @(negedge clk);

    // Restart, overwrite row 3 mid-dwell, then drop en in row 5's third dwell cycle.
    drv_en = 1'b0;
    repeat (3) @(negedge clk);
    drv_en = 1'b1;
    repeat (17) @(negedge clk);
    drv_wr_en   = 1'b1;
    drv_wr_addr = 3'd3;
    drv_wr_data = 8'hA5;
    @(negedge clk);
    drv_wr_en = 1'b0;
    repeat (10) @(negedge clk);
    drv_en = 1'b0;
    repeat (3) @(negedge clk);
    drv_en = 1'b1;
    repeat (60) @(negedge clk);

    // Restart and pulse reset during row 7's blanking.
    drv_en = 1'b0;
    repeat (2) @(negedge clk);
    drv_en = 1'b1;
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // Random writes with occasional enable drops.
    for (int i = 0; i < 800; i++) begin
      drv_wr_en   = ($urandom_range(0, 3) == 0);
      drv_wr_addr = 3'($urandom_range(0, 7));
      drv_wr_data = 8'($urandom_range(0, 255));
      drv_en      = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    drv_wr_en = 1'b0;
    drv_en    = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
